// File: rtl/sfp_pkg.sv
// rtl/sfp_pkg.sv - shared constants, state type and beat builders for the SFP frame packer
package sfp_pkg;

    localparam logic [15:0] HDR_MAGIC = 16'h5AA5;
    localparam logic [15:0] TRL_MAGIC = 16'hA55A;

    localparam logic [7:0] FRAME_TYPE_STATUS = 8'h01;

    localparam int HDR_MAGIC_LSB = 48;
    localparam int HDR_TYPE_LSB  = 40;
    localparam int HDR_ID_LSB    = 32;
    localparam int HDR_SEQ_LSB   = 16;
    localparam int HDR_LEN_LSB   = 0;

    localparam int TRL_MAGIC_LSB = 48;
    localparam int TRL_SEQ_LSB   = 32;
    localparam int TRL_CSUM_LSB  = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2,
        TRL  = 2'd3
    } sfp_state_t;

    function automatic logic [63:0] make_header(
        input logic [7:0]  ftype,
        input logic [7:0]  node_id,
        input logic [15:0] seq,
        input logic [15:0] len
    );
        logic [63:0] hdr;
        hdr = '0;
        hdr[HDR_MAGIC_LSB +: 16] = HDR_MAGIC;
        hdr[HDR_TYPE_LSB  +: 8]  = ftype;
        hdr[HDR_ID_LSB    +: 8]  = node_id;
        hdr[HDR_SEQ_LSB   +: 16] = seq;
        hdr[HDR_LEN_LSB   +: 16] = len;
        return hdr;
    endfunction

    function automatic logic [63:0] make_trailer(
        input logic [15:0] seq,
        input logic [31:0] csum
    );
        logic [63:0] trl;
        trl = '0;
        trl[TRL_MAGIC_LSB +: 16] = TRL_MAGIC;
        trl[TRL_SEQ_LSB   +: 16] = seq;
        trl[TRL_CSUM_LSB  +: 32] = csum;
        return trl;
    endfunction

endpackage

// File: rtl/sfp_word_snapshot.sv
// rtl/sfp_word_snapshot.sv - status word register bank with XOR checksum and beat-pair readout
module sfp_word_snapshot
    import sfp_pkg::*;
#(
    parameter int NUM_WORDS = 9,
    parameter int SEL_W     = 3
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   snap,
    input  logic [NUM_WORDS*32-1:0] words,
    input  logic [SEL_W-1:0]       pair_sel,
    output logic [63:0]            pair_data,
    output logic [31:0]            checksum
);

    localparam int NB = (NUM_WORDS + 1) / 2;

    logic [NB*64-1:0] bank_q;
    logic [NB*64-1:0] bank_d;
    logic [31:0]      csum_d;

    // Pad to whole beats so an odd word count leaves the final upper half at zero.
    always_comb begin
        bank_d = '0;
        bank_d[NUM_WORDS*32-1:0] = words;
    end

    always_comb begin
        csum_d = '0;
        for (int k = 0; k < NUM_WORDS; k++) begin
            csum_d = csum_d ^ words[k*32 +: 32];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bank_q   <= '0;
            checksum <= '0;
        end else if (snap) begin
            bank_q   <= bank_d;
            checksum <= csum_d;
        end
    end

    always_comb begin
        pair_data = '0;
        for (int j = 0; j < NB; j++) begin
            if (pair_sel == SEL_W'(j)) begin
                pair_data = bank_q[j*64 +: 64];
            end
        end
    end

endmodule

// File: rtl/sfp_frame_packer.sv
// rtl/sfp_frame_packer.sv - frames a status word snapshot into a 64-bit stream packet
module sfp_frame_packer
    import sfp_pkg::*;
#(
    parameter int         NUM_WORDS  = 9,
    parameter int         ID_W       = 2,
    parameter logic [7:0] FRAME_TYPE = FRAME_TYPE_STATUS,
    parameter int         CNT_W      = 32
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_en,
    input  logic                    i_channel_up,
    input  logic [ID_W-1:0]         i_id,
    input  logic                    i_trig,
    input  logic [NUM_WORDS*32-1:0] i_words,
    output logic [63:0]             m_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast,
    output logic                    o_busy,
    output logic [15:0]             o_seq,
    output logic [CNT_W-1:0]        o_frame_cnt,
    output logic [CNT_W-1:0]        o_overrun_cnt,
    output logic [CNT_W-1:0]        o_abort_cnt
);

    localparam int               NB        = (NUM_WORDS + 1) / 2;
    localparam int               SEL_W     = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [SEL_W-1:0] LAST_BEAT = SEL_W'(NB - 1);
    localparam logic [15:0]      LEN       = 16'(NUM_WORDS);

    sfp_state_t       state;
    sfp_state_t       state_n;
    logic             pending;
    logic             pending_n;
    logic             snap;
    logic             frame_done;
    logic             overrun_evt;
    logic             abort_evt;
    logic             beat_inc;
    logic             accept;
    logic             trl_accept;
    logic [SEL_W-1:0] beat_idx;
    logic [15:0]      seq_q;
    logic [7:0]       id_q;
    logic [63:0]      pair_data;
    logic [31:0]      checksum;

    assign m_axis_tvalid = (state != IDLE);
    assign o_busy        = (state != IDLE);
    assign o_seq         = seq_q;
    assign accept        = m_axis_tvalid && m_axis_tready;
    assign trl_accept    = (state == TRL) && accept;

    sfp_word_snapshot #(
        .NUM_WORDS (NUM_WORDS),
        .SEL_W     (SEL_W)
    ) u_snapshot (
        .clk       (i_clk),
        .resetn    (i_rst),
        .snap      (snap),
        .words     (i_words),
        .pair_sel  (beat_idx),
        .pair_data (pair_data),
        .checksum  (checksum)
    );

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n     = state;
        pending_n   = pending;
        snap        = 1'b0;
        frame_done  = 1'b0;
        overrun_evt = 1'b0;
        abort_evt   = 1'b0;
        beat_inc    = 1'b0;

        case (state)
            IDLE: begin
                if (i_trig && i_en && i_channel_up) begin
                    snap    = 1'b1;
                    state_n = HDR;
                end
            end
            HDR: begin
                if (accept) begin
                    state_n = DATA;
                end
            end
            DATA: begin
                if (accept) begin
                    if (beat_idx == LAST_BEAT) begin
                        state_n = TRL;
                    end else begin
                        beat_inc = 1'b1;
                    end
                end
            end
            TRL: begin
                if (accept) begin
                    frame_done = 1'b1;
                    if (pending || i_trig) begin
                        snap    = 1'b1;
                        state_n = HDR;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // A trigger landing on trailer acceptance is folded into the restart, never an overrun.
        if (trl_accept) begin
            pending_n = pending && i_trig;
        end else if ((state != IDLE) && i_trig) begin
            if (pending) begin
                overrun_evt = 1'b1;
            end else begin
                pending_n = 1'b1;
            end
        end

        if ((state != IDLE) && (!i_en || !i_channel_up)) begin
            state_n     = IDLE;
            pending_n   = 1'b0;
            snap        = 1'b0;
            frame_done  = 1'b0;
            overrun_evt = 1'b0;
            beat_inc    = 1'b0;
            abort_evt   = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            pending       <= 1'b0;
            beat_idx      <= '0;
            seq_q         <= '0;
            id_q          <= '0;
            o_frame_cnt   <= '0;
            o_overrun_cnt <= '0;
            o_abort_cnt   <= '0;
        end else begin
            pending <= pending_n;
            if (snap) begin
                beat_idx <= '0;
                id_q     <= 8'(i_id);
            end else if (beat_inc) begin
                beat_idx <= beat_idx + SEL_W'(1);
            end
            if (frame_done) begin
                seq_q <= seq_q + 16'd1;
                if (o_frame_cnt != '1) begin
                    o_frame_cnt <= o_frame_cnt + CNT_W'(1);
                end
            end
            if (overrun_evt && (o_overrun_cnt != '1)) begin
                o_overrun_cnt <= o_overrun_cnt + CNT_W'(1);
            end
            if (abort_evt && (o_abort_cnt != '1)) begin
                o_abort_cnt <= o_abort_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        m_axis_tdata = '0;
        m_axis_tlast = 1'b0;
        case (state)
            HDR:  m_axis_tdata = make_header(FRAME_TYPE, id_q, seq_q, LEN);
            DATA: m_axis_tdata = pair_data;
            TRL: begin
                m_axis_tdata = make_trailer(seq_q, checksum);
                m_axis_tlast = 1'b1;
            end
            default: m_axis_tdata = '0;
        endcase
    end

endmodule

// File: doc/sfp_frame_packer.md
Name: sfp_frame_packer

Overview:
- Parametrised successor to the fixed nine-word SFP status path.
- Snapshots NUM_WORDS 32-bit MPS status words (interlocks, currents, voltages, RMS phases, ...) on a trigger.
- Emits them as one framed 64-bit AXI4-Stream packet: header beat, packed data beats, trailer beat with tlast and XOR checksum.
- Sits between the MPS measurement logic and the Aurora SFP TX stream; adds sequence numbering, backpressure, a one-deep trigger queue and link-down abort.

Parameters:
- NUM_WORDS, 9, number of 32-bit status words per frame (1..64).
- ID_W, 2, width of the SFP node ID.
- FRAME_TYPE, 8'h01, frame type code placed in the header.
- CNT_W, 32, width of the statistics counters.

Ports:
- i_clk  in  1  system clock (200 MHz domain).
- i_rst  in  1  asynchronous active-low reset.
- i_en  in  1  packer enable.
- i_channel_up  in  1  Aurora channel up.
- i_id  in  ID_W  local SFP node ID.
- i_trig  in  1  single-cycle frame request.
- i_words  in  NUM_WORDS*32  status words; word k = bits [32k+31:32k].
- m_axis_tdata  out  64  frame beat.
- m_axis_tvalid  out  1  beat valid.
- m_axis_tready  in  1  sink ready.
- m_axis_tlast  out  1  last beat of frame (trailer).
- o_busy  out  1  frame in progress.
- o_seq  out  16  sequence number of the next frame.
- o_frame_cnt  out  CNT_W  completed frames.
- o_overrun_cnt  out  CNT_W  dropped triggers.
- o_abort_cnt  out  CNT_W  aborted frames.

Behaviour:
- Reset (i_rst=0, asynchronous): all outputs 0, state IDLE, pending flag 0, seq 0. Reset mid-frame kills the frame with no tlast.
- State machine: IDLE -> HDR -> DATA -> TRL -> IDLE, or TRL -> HDR when a trigger is pending.
- Start: in IDLE, i_trig=1 with i_en=1 and i_channel_up=1 in cycle t.
  - i_words is snapshotted into a register bank and the XOR checksum is computed at t.
  - Header is presented (tvalid=1) at t+1.
  - i_trig is ignored while i_en=0 or the channel is down.
- Header beat: [63:48]=16'h5AA5, [47:40]=FRAME_TYPE, [39:32]=zero-extended i_id (sampled at snapshot), [31:16]=seq, [15:0]=NUM_WORDS.
- Data beats: NB=ceil(NUM_WORDS/2) beats. Beat j = {word[2j+1], word[2j]}, lower word in [31:0]. With odd NUM_WORDS, the upper half of the final beat is 0.
- Trailer beat: [63:48]=16'hA55A, [47:32]=seq, [31:0]=XOR of all snapshot words; tlast=1 only on this beat.
- Handshake:
  - A beat advances only on tvalid & tready.
  - tdata and tlast are held stable while tvalid=1 and tready=0.
  - tvalid stays 1 between beats within a frame, giving zero bubbles under continuous tready.
- Frame completion, on trailer acceptance:
  - seq increments and wraps at 16'hFFFF -> 0.
  - o_frame_cnt increments.
- Trigger during a frame: sets the pending flag.
  - A trigger while pending is already set increments o_overrun_cnt and is otherwise dropped.
  - A trigger in the same cycle as trailer acceptance counts as pending, not overrun.
- Pending service: a new snapshot is taken in the trailer-accept cycle and the next header is valid in the following cycle, giving back-to-back frames. Pending is cleared.
- Abort: i_channel_up=0 or i_en=0 while not IDLE.
  - tvalid drops the next cycle (a permitted AXIS exception on link loss) and the state returns to IDLE.
  - Pending is cleared, o_abort_cnt increments, and seq is unchanged.
- Counters saturate at all-ones.
- o_busy=1 whenever the state is not IDLE.

Decomposition:
- Shared package sfp_pkg holds:
  - header and trailer magic constants (16'h5AA5, 16'hA55A);
  - frame type codes;
  - state enum (IDLE, HDR, DATA, TRL);
  - header field offsets.
- One natural sub-module, sfp_word_snapshot: the register bank plus XOR reduction, parameterised by NUM_WORDS. It provides the snapshot strobe, word-pair select and checksum outputs.

Test Plan:
- NUM_WORDS=9, i_id=2, words 0x1000_0000+k, tready=1, single trigger -> 7 beats: header 0x5AA5_0102_0000_0009, data 0x10000001_10000000 ... last data 0x00000000_10000008, trailer 0xA55A_0000_XXXX with XOR=0x10000008, tlast on beat 7; seq becomes 1, o_frame_cnt=1.
- Same frame with tready toggling 1/0 every cycle -> identical beat sequence, tdata stable during stalls, 7 accepted beats over 13 cycles.
- Triggers at header+2 and header+3 -> second frame starts in the cycle after trailer acceptance with seq=1; o_overrun_cnt=1.
- i_channel_up dropped during data beat 3 -> tvalid=0 the next cycle, no tlast, o_abort_cnt=1, seq stays 0; the next trigger yields a full frame with seq=0.
- NUM_WORDS=1 build -> 3 beats: header, {0, word0}, trailer with checksum=word0.
- Async reset asserted mid-frame -> tvalid, o_busy and all counters go to 0 immediately; after release, a trigger produces a header with seq 0.
